vga_sprite_loader: RTL and testbench

- Write-side counterpart of the sprite renderer. Accepts a byte stream with a valid/ready handshake and a start-of-packet marker.
- Deserialises each 9-byte packet into a shadow copy of one sprite's configuration: 32-bit pixel row, pixel size, three start times.
- Commits the shadow copy to the renderer-facing outputs only on a commit strobe, normally driven at start of horizontal blank. The renderer therefore never sees a half-written sprite mid-line.

---
 rtl/vga_sprite_loader.sv | 186 ++++++++++++++++++
 tb/tb_vga_sprite_loader.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_loader.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sprite_loader
//  Description : Byte-stream loader for one sprite's configuration. Each
//                9-byte packet fills a shadow copy of the sprite. The shadow
//                is copied to the renderer-facing registers only on a commit
//                strobe, so the renderer never sees a half-written sprite.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sprite_loader #(
    parameter logic [9:0] RESET_START_TIME = 10'd1023,
    parameter int         PACKET_BYTES     = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    input  logic        wr_sop,
    output logic        wr_ready,
    input  logic        commit,
    output logic [31:0] sprite_pixels,
    output logic [5:0]  sprite_pixel_size,
    output logic [9:0]  start_time_0,
    output logic [9:0]  start_time_1,
    output logic [9:0]  start_time_2,
    output logic        pending,
    output logic        sop_error
);

    // Index of the final byte of a packet.
    localparam logic [3:0] c_last_idx = 4'(PACKET_BYTES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_byte_idx;
    logic [3:0]  w_idx_next;
    logic [3:0]  w_wr_idx;
    logic        w_wr_en;
    logic        w_set_err;
    logic        w_complete;
    logic        w_xfer;
    logic        w_do_commit;

    // Shadow copy of the sprite being loaded.
    logic [31:0] r_sh_pixels;
    logic [5:0]  r_sh_size;
    logic [9:0]  r_sh_st0;
    logic [9:0]  r_sh_st1;
    logic [9:0]  r_sh_st2;
    // Start-time bytes 5..7 are held here until byte 8 completes the word.
    logic [23:0] r_stage;
    // Start-time word as seen on the byte-8 edge; W[31:30] are ignored.
    logic [29:0] w_word;

    assign wr_ready    = !pending;
    assign w_xfer      = wr_valid && wr_ready;
    assign w_do_commit = commit && pending;
    assign w_word      = {wr_data[5:0], r_stage};

    // State and byte-index register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_byte_idx <= 4'd0;
        end else begin
            r_state    <= w_state_next;
            r_byte_idx <= w_idx_next;
        end
    end

    // Next-state logic: decide which shadow byte to write and flag errors.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_byte_idx;
        w_wr_en      = 1'b0;
        w_wr_idx     = r_byte_idx;
        w_set_err    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (wr_sop) begin
                        w_wr_en      = 1'b1;
                        w_wr_idx     = 4'd0;
                        w_idx_next   = 4'd1;
                        w_state_next = ST_LOAD;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_xfer) begin
                    w_wr_en = 1'b1;
                    if (wr_sop) begin
                        // Restart: this byte becomes byte 0 of a new packet.
                        w_wr_idx   = 4'd0;
                        w_idx_next = 4'd1;
                        w_set_err  = 1'b1;
                    end else if (r_byte_idx == c_last_idx) begin
                        w_complete   = 1'b1;
                        w_idx_next   = 4'd0;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_idx_next = r_byte_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = 4'd0;
            end
        endcase
    end

    // Write accepted bytes straight into the shadow fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh_pixels <= 32'd0;
            r_sh_size   <= 6'd0;
            r_sh_st0    <= RESET_START_TIME;
            r_sh_st1    <= RESET_START_TIME;
            r_sh_st2    <= RESET_START_TIME;
            r_stage     <= 24'd0;
        end else if (w_wr_en) begin
            case (w_wr_idx)
                4'd0: r_sh_pixels[7:0]   <= wr_data;
                4'd1: r_sh_pixels[15:8]  <= wr_data;
                4'd2: r_sh_pixels[23:16] <= wr_data;
                4'd3: r_sh_pixels[31:24] <= wr_data;
                4'd4: r_sh_size          <= wr_data[5:0];
                4'd5: r_stage[7:0]       <= wr_data;
                4'd6: r_stage[15:8]      <= wr_data;
                4'd7: r_stage[23:16]     <= wr_data;
                4'd8: begin
                    r_sh_st0 <= w_word[9:0];
                    r_sh_st1 <= w_word[19:10];
                    r_sh_st2 <= w_word[29:20];
                end
                default: ;
            endcase
        end
    end

    // Pending flag and sticky error flag. A completing packet can only arrive
    // while pending is low, so a same-edge commit never clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending   <= 1'b0;
            sop_error <= 1'b0;
        end else begin
            if (w_complete) begin
                pending <= 1'b1;
            end else if (w_do_commit) begin
                pending <= 1'b0;
            end
            if (w_set_err) begin
                sop_error <= 1'b1;
            end
        end
    end

    // Renderer-facing registers update only on a commit of a complete shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sprite_pixels     <= 32'd0;
            sprite_pixel_size <= 6'd0;
            start_time_0      <= RESET_START_TIME;
            start_time_1      <= RESET_START_TIME;
            start_time_2      <= RESET_START_TIME;
        end else if (w_do_commit) begin
            sprite_pixels     <= r_sh_pixels;
            sprite_pixel_size <= r_sh_size;
            start_time_0      <= r_sh_st0;
            start_time_1      <= r_sh_st1;
            start_time_2      <= r_sh_st2;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sprite_loader
//  Description : Self-checking bench for vga_sprite_loader. Expected committed
//                sprites are queued by the stimulus; a monitor pops and
//                compares them whenever a commit takes effect.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sprite_loader;

    logic        clk;
    logic        reset_n;
    logic        wr_valid;
    logic [7:0]  wr_data;
    logic        wr_sop;
    logic        wr_ready;
    logic        commit;
    logic [31:0] sprite_pixels;
    logic [5:0]  sprite_pixel_size;
    logic [9:0]  start_time_0;
    logic [9:0]  start_time_1;
    logic [9:0]  start_time_2;
    logic        pending;
    logic        sop_error;

    typedef struct {
        logic [31:0] px;
        logic [5:0]  sz;
        logic [9:0]  t0;
        logic [9:0]  t1;
        logic [9:0]  t2;
    } cfg_t;

    cfg_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic r_prev_pending = 1'b0;

    vga_sprite_loader dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .wr_valid          (wr_valid),
        .wr_data           (wr_data),
        .wr_sop            (wr_sop),
        .wr_ready          (wr_ready),
        .commit            (commit),
        .sprite_pixels     (sprite_pixels),
        .sprite_pixel_size (sprite_pixel_size),
        .start_time_0      (start_time_0),
        .start_time_1      (start_time_1),
        .start_time_2      (start_time_2),
        .pending           (pending),
        .sop_error         (sop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name, input cfg_t e);
        check({name, ".pixels"}, sprite_pixels, e.px);
        check({name, ".size"}, 32'(sprite_pixel_size), 32'(e.sz));
        check({name, ".t0"}, 32'(start_time_0), 32'(e.t0));
        check({name, ".t1"}, 32'(start_time_1), 32'(e.t1));
        check({name, ".t2"}, 32'(start_time_2), 32'(e.t2));
    endtask

    // Monitor: a falling pending while out of reset means a commit landed.
    always @(negedge clk) begin
        if (reset_n && r_prev_pending && !pending) begin
            if (q_exp.size() == 0) begin
                check("commit_unexpected", 32'd1, 32'd0);
            end else begin
                check_outputs("commit", q_exp.pop_front());
            end
        end
        r_prev_pending = pending;
    end

    // Present one byte and hold it until it transfers (bounded wait).
    task automatic send_byte(input logic [7:0] d, input logic sop, input logic cm);
        bit done = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_sop   = sop;
        commit   = cm;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (wr_ready) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        commit   = 1'b0;
        wr_valid = 1'b0;
        wr_sop   = 1'b0;
    endtask

    // Send bytes first..last of a packet held LSB-byte-first in pk.
    task automatic send_bytes(input logic [71:0] pk, input int first, input int last,
                              input logic cm_last);
        for (int i = first; i <= last; i++) begin
            send_byte(pk[8*i +: 8], (i == 0), (i == 8) ? cm_last : 1'b0);
        end
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [71:0] c_pk_a = 72'h1F_40_54_0A_03_44_33_22_11;
    localparam logic [71:0] c_pk_b = 72'hD2_C3_20_64_C5_12_34_56_78;
    localparam logic [71:0] c_pk_c = 72'h00_1F_FC_00_3F_66_77_88_99;
    localparam logic [71:0] c_pk_d = 72'h00_30_08_01_07_04_03_02_01;
    localparam logic [71:0] c_pk_j = 72'h00_00_00_00_00_EF_BE_AD_DE;
    localparam logic [71:0] c_pk_f = 72'h3F_E0_06_7F_2A_3C_C3_5A_A5;

    cfg_t c_rst = '{px: 32'h0,        sz: 6'd0,  t0: 10'd1023, t1: 10'd1023, t2: 10'd1023};
    cfg_t c_a   = '{px: 32'h44332211, sz: 6'd3,  t0: 10'd10,   t1: 10'd21,   t2: 10'd500};
    cfg_t c_b   = '{px: 32'h12345678, sz: 6'd5,  t0: 10'd100,  t1: 10'd200,  t2: 10'd300};
    cfg_t c_c   = '{px: 32'h66778899, sz: 6'd63, t0: 10'd0,    t1: 10'd1023, t2: 10'd1};
    cfg_t c_d   = '{px: 32'h04030201, sz: 6'd7,  t0: 10'd1,    t1: 10'd2,    t2: 10'd3};
    cfg_t c_f   = '{px: 32'h3CC35AA5, sz: 6'd42, t0: 10'd639,  t1: 10'd1,    t2: 10'd1022};

    initial begin
        wr_valid = 1'b0;
        wr_data  = 8'h00;
        wr_sop   = 1'b0;
        commit   = 1'b0;
        reset_n  = 1'b0;
        do_reset();

        // Reset state.
        check_outputs("reset", c_rst);
        check("reset.ready", 32'(wr_ready), 32'd1);
        check("reset.pending", 32'(pending), 32'd0);
        check("reset.sop_error", 32'(sop_error), 32'd0);

        // Packet A: pending after byte 8, outputs hold until commit.
        send_bytes(c_pk_a, 0, 8, 1'b0);
        check("a.pending", 32'(pending), 32'd1);
        check("a.ready", 32'(wr_ready), 32'd0);
        check_outputs("a.hold", c_rst);
        q_exp.push_back(c_a);
        pulse_commit();
        check("a.pending_clr", 32'(pending), 32'd0);

        // Packet B: byte 8 coincides with commit; commit must be ignored.
        send_bytes(c_pk_b, 0, 8, 1'b1);
        check("b.pending", 32'(pending), 32'd1);
        check_outputs("b.hold", c_a);
        q_exp.push_back(c_b);

        // Backpressure: byte 0 of packet C held for 5 cycles while pending.
        wr_valid = 1'b1;
        wr_data  = c_pk_c[7:0];
        wr_sop   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.ready", 32'(wr_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        commit = 1'b1;
        @(posedge clk);
        #1;
        commit = 1'b0;
        check("bp.ready_after_commit", 32'(wr_ready), 32'd1);
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_sop   = 1'b0;
        send_bytes(c_pk_c, 1, 8, 1'b0);
        check("c.sop_error", 32'(sop_error), 32'd0);
        q_exp.push_back(c_c);
        pulse_commit();

        // Restart mid-packet: 4 junk bytes then a fresh packet D.
        send_bytes(c_pk_j, 0, 3, 1'b0);
        check("restart.no_err_yet", 32'(sop_error), 32'd0);
        send_bytes(c_pk_d, 0, 8, 1'b0);
        check("restart.sop_error", 32'(sop_error), 32'd1);
        q_exp.push_back(c_d);
        pulse_commit();

        // Byte without sop in IDLE is dropped and flagged.
        do_reset();
        check("idle.err_clr", 32'(sop_error), 32'd0);
        check_outputs("reset2", c_rst);
        send_byte(8'h55, 1'b0, 1'b0);
        check("idle.sop_error", 32'(sop_error), 32'd1);
        check("idle.pending", 32'(pending), 32'd0);
        send_bytes(c_pk_a, 0, 8, 1'b0);
        q_exp.push_back(c_a);
        pulse_commit();

        // Async reset after byte 5 of a packet, with no clock edge.
        send_bytes(c_pk_f, 0, 5, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", c_rst);
        check("async_rst.sop_error", 32'(sop_error), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_bytes(c_pk_f, 0, 8, 1'b0);
        q_exp.push_back(c_f);
        pulse_commit();

        repeat (3) @(posedge clk);
        check("queue_empty", 32'(q_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
